// File: rtl/fifo_uart_rr_controller_pkg.sv
// Shared state encoding, constants and helpers for the round-robin FIFO-to-UART controller.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FETCH       = 3'd1,
        SEND        = 3'd2,
        WAIT_HI     = 3'd3,
        WAIT_LO     = 3'd4,
        HDR_SEND    = 3'd5,
        HDR_WAIT_HI = 3'd6,
        HDR_WAIT_LO = 3'd7
    } ctrl_state_t;

    localparam int         BUSY_TIMEOUT = 32'sd2;
    localparam logic [3:0] TAG_MARKER   = 4'hF;

    // A single channel still needs a one-bit index.
    function automatic int ch_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    function automatic logic [7:0] tag_header(input logic [3:0] ch);
        return {TAG_MARKER, ch};
    endfunction

endpackage

// File: rtl/fifo_uart_rr_controller_if.sv
// FIFO read-side and uart_tx handshake bundle; master is the controller, slave the surrounding logic.
interface fifo_uart_rr_controller_if
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
);
    localparam int CH_W = ch_width(N_CH);

    logic                  i_enable;
    logic [N_CH-1:0]       i_ch_mask;
    logic [N_CH-1:0]       i_empty;
    logic [N_CH*WIDTH-1:0] i_r_data;
    logic [N_CH-1:0]       o_r_en;
    logic                  i_busy;
    logic                  o_dv;
    logic [WIDTH-1:0]      o_data;
    logic [CH_W-1:0]       o_ch;
    logic                  o_active;

    modport master (
        input  i_enable, i_ch_mask, i_empty, i_r_data, i_busy,
        output o_r_en, o_dv, o_data, o_ch, o_active
    );

    modport slave (
        output i_enable, i_ch_mask, i_empty, i_r_data, i_busy,
        input  o_r_en, o_dv, o_data, o_ch, o_active
    );

endinterface

// File: rtl/fifo_uart_rr_controller_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    int idx_s;

    // Scan from the pointer; the first hit wins and later hits are ignored.
    always_comb begin
        grant     = {N{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        valid     = 1'b0;
        idx_s     = 32'sd0;
        for (int i = 0; i < N; i++) begin
            idx_s = (int'(ptr) + i) % N;
            if (!valid && req[idx_s]) begin
                valid        = 1'b1;
                grant_idx    = IDX_W'(idx_s);
                grant[idx_s] = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/fifo_uart_rr_controller.sv
// Drains N_CH FIFOs into one uart_tx, one word per round-robin grant.
// Optional channel header words are enabled with `define FIFO_UART_CH_TAG_EN.
module fifo_uart_rr_controller
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
) (
    input  logic                        clk,
    input  logic                        i_reset,
    fifo_uart_rr_controller_if.master   bus
);

    localparam int CH_W = ch_width(N_CH);

    ctrl_state_t      state_r, state_s;
    logic [CH_W-1:0]  ptr_r, ptr_s;
    logic [CH_W-1:0]  ch_r, ch_s;
    logic [N_CH-1:0]  r_en_r, r_en_s;
    logic             dv_r, dv_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic [1:0]       tmo_r, tmo_s;
    logic             active_r;
    logic [N_CH-1:0]  req_s, gnt_s;
    logic [CH_W-1:0]  gnt_idx_s;
    logic             gnt_vld_s;
`ifdef FIFO_UART_CH_TAG_EN
    // Top bit set marks "no channel sent yet", so the first word is always tagged.
    logic [CH_W:0]    last_r, last_s;
`endif

    assign req_s = ~bus.i_empty & bus.i_ch_mask;

    rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
        .req       (req_s),
        .ptr       (ptr_r),
        .grant     (gnt_s),
        .grant_idx (gnt_idx_s),
        .valid     (gnt_vld_s)
    );

    // Next-state and next-output logic; enable, mask and empty only matter in IDLE.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        ch_s    = ch_r;
        r_en_s  = {N_CH{1'b0}};
        dv_s    = 1'b0;
        data_s  = data_r;
        tmo_s   = 2'd0;
`ifdef FIFO_UART_CH_TAG_EN
        last_s  = last_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.i_enable && gnt_vld_s && !bus.i_busy) begin
                    ch_s  = gnt_idx_s;
                    ptr_s = (gnt_idx_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : gnt_idx_s + 1'b1;
`ifdef FIFO_UART_CH_TAG_EN
                    last_s = {1'b0, gnt_idx_s};
                    if (last_r != {1'b0, gnt_idx_s}) begin
                        state_s = HDR_SEND;
                        dv_s    = 1'b1;
                        data_s  = WIDTH'(tag_header(4'(gnt_idx_s)));
                    end else begin
                        state_s = FETCH;
                        r_en_s  = gnt_s;
                    end
`else
                    state_s = FETCH;
                    r_en_s  = gnt_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                data_s  = bus.i_r_data[int'(ch_r)*WIDTH +: WIDTH];
                dv_s    = 1'b1;
                state_s = SEND;
            end
            SEND: begin
                state_s = WAIT_HI;
            end
            WAIT_HI: begin
                // A UART that finishes instantly never shows busy; give up after the timeout.
                if (bus.i_busy) begin
                    state_s = WAIT_LO;
                end else if (tmo_r == 2'(BUSY_TIMEOUT - 1)) begin
                    state_s = IDLE;
                end else begin
                    tmo_s = tmo_r + 2'd1;
                end
            end
            WAIT_LO: begin
                if (!bus.i_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LO;
                end
            end
`ifdef FIFO_UART_CH_TAG_EN
            HDR_SEND: begin
                state_s = HDR_WAIT_HI;
            end
            HDR_WAIT_HI: begin
                if (bus.i_busy) begin
                    state_s = HDR_WAIT_LO;
                end else if (tmo_r == 2'(BUSY_TIMEOUT - 1)) begin
                    state_s      = FETCH;
                    r_en_s[ch_r] = 1'b1;
                end else begin
                    tmo_s = tmo_r + 2'd1;
                end
            end
            HDR_WAIT_LO: begin
                if (!bus.i_busy) begin
                    state_s      = FETCH;
                    r_en_s[ch_r] = 1'b1;
                end else begin
                    state_s = HDR_WAIT_LO;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts a transfer and drops any popped word.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r  <= IDLE;
            ptr_r    <= {CH_W{1'b0}};
            ch_r     <= {CH_W{1'b0}};
            r_en_r   <= {N_CH{1'b0}};
            dv_r     <= 1'b0;
            data_r   <= {WIDTH{1'b0}};
            tmo_r    <= 2'd0;
            active_r <= 1'b0;
`ifdef FIFO_UART_CH_TAG_EN
            last_r   <= {1'b1, {CH_W{1'b0}}};
`endif
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            ch_r     <= ch_s;
            r_en_r   <= r_en_s;
            dv_r     <= dv_s;
            data_r   <= data_s;
            tmo_r    <= tmo_s;
            active_r <= (state_s != IDLE);
`ifdef FIFO_UART_CH_TAG_EN
            last_r   <= last_s;
`endif
        end
    end

    assign bus.o_r_en   = r_en_r;
    assign bus.o_dv     = dv_r;
    assign bus.o_data   = data_r;
    assign bus.o_ch     = ch_r;
    assign bus.o_active = active_r;

endmodule

// File: tb/tb_fifo_uart_rr_controller.sv
// Bench for fifo_uart_rr_controller: FIFO and uart_tx models with a word scoreboard.
module tb_fifo_uart_rr_controller;

    localparam int WIDTH    = 8;
    localparam int N_CH     = 4;
    localparam int BUSY_LEN = 12;
    localparam int TMO      = 2000;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    logic clk = 1'b0;
    logic i_reset;

    fifo_uart_rr_controller_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

    fifo_uart_rr_controller #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] fifo_data [N_CH];
    int         mptr = 0;
    int         mlast = -1;
    int         ren_count = 0;
    int         ren_ch = 0;
    int         last_gap = 0;
    int         cyc = 0;
    int         last_ren_cyc = -1;
    int         busy_cnt = 0;
    bit         uart_silent = 1'b0;
    logic       prev_dv = 1'b0;

    for (genvar c = 0; c < N_CH; c++) begin : g_fifo
        assign bus.i_r_data[c*WIDTH +: WIDTH] = fifo_data[c];
    end

    // Read-strobe monitor: one-hot, matches o_ch, and at least 5 cycles apart.
    always @(negedge clk) begin
        cyc++;
        if (i_reset) last_ren_cyc = -1;
        if (bus.o_r_en != 4'b0000) begin
            n_checks++;
            if (!$onehot(bus.o_r_en) || bus.o_r_en[bus.o_ch] !== 1'b1) begin
                n_errors++;
                $display("FAIL r_en_onehot: o_r_en=%b o_ch=%0d, required one-hot at o_ch", bus.o_r_en, bus.o_ch);
            end
            if (last_ren_cyc >= 0) begin
                last_gap = cyc - last_ren_cyc;
                n_checks++;
                if (last_gap < 5) begin
                    n_errors++;
                    $display("FAIL r_en_spacing: gap=%0d cycles, required >= 5", last_gap);
                end
            end
            last_ren_cyc = cyc;
            ren_count++;
            for (int c = 0; c < N_CH; c++) if (bus.o_r_en[c]) ren_ch = c;
        end
    end

    // uart_tx model: pops the scoreboard on o_dv, then raises busy unless in instant mode.
    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.i_busy = 1'b0;
        end
        if (bus.o_dv === 1'b1) begin
            n_checks++;
            if (prev_dv === 1'b1) begin
                n_errors++;
                $display("FAIL dv_pulse: o_dv high two cycles in a row, required single cycle");
            end else if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL uart_word: got %h ch %0d, required no word", bus.o_data, bus.o_ch);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_data !== e.data || bus.o_ch !== e.ch) begin
                    n_errors++;
                    $display("FAIL uart_word: got %h ch %0d, required %h ch %0d", bus.o_data, bus.o_ch, e.data, e.ch);
                end
            end
            if (!uart_silent) begin
                bus.i_busy = 1'b1;
                busy_cnt   = BUSY_LEN;
            end
        end
        prev_dv = bus.o_dv;
    end

    function automatic int model_grant(input logic [3:0] req, input int p);
        for (int i = 0; i < N_CH; i++) if (req[(p + i) % N_CH]) return (p + i) % N_CH;
        return -1;
    endfunction

    task automatic model_reset();
        mptr  = 0;
        mlast = -1;
    endtask

    // Push the words the next n grants should produce, given current empty/mask.
    task automatic queue_words(input int n);
        logic [3:0] req;
        int g;
        req = ~bus.i_empty & bus.i_ch_mask;
        for (int k = 0; k < n; k++) begin
            g = model_grant(req, mptr);
            if (g >= 0) begin
`ifdef FIFO_UART_CH_TAG_EN
                if (g != mlast) exp_q.push_back('{data: {4'hF, 4'(g)}, ch: 2'(g)});
                mlast = g;
`endif
                exp_q.push_back('{data: fifo_data[g], ch: 2'(g)});
                mptr = (g + 1) % N_CH;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || bus.o_active !== 1'b0 || bus.i_busy) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || bus.o_active !== 1'b0) begin
            n_errors++;
            $display("FAIL drain: %0d words outstanding, o_active=%b, required 0 and 0", exp_q.size(), bus.o_active);
        end
    endtask

    // Enable until n read strobes are seen, then disable and let the last word finish.
    task automatic run_words(input int n);
        int k = 0;
        int t = 0;
        bus.i_enable = 1'b1;
        while (k < n && t < TMO) begin
            @(negedge clk);
            t++;
            if (bus.o_r_en != 4'b0000) k++;
        end
        bus.i_enable = 1'b0;
        n_checks++;
        if (k != n) begin
            n_errors++;
            $display("FAIL grant_count: got %0d grants, required %0d", k, n);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        bus.i_enable  = 1'b1;
        bus.i_ch_mask = 4'hF;
        bus.i_empty   = 4'h0;
        i_reset       = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.o_r_en !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_r_en: o_r_en=%b during reset, required 0000", bus.o_r_en);
            end
        end
        n_checks += 4;
        if (bus.o_dv !== 1'b0) begin n_errors++; $display("FAIL reset_dv: got %b, required 0", bus.o_dv); end
        if (bus.o_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h, required 00", bus.o_data); end
        if (bus.o_ch !== 2'd0) begin n_errors++; $display("FAIL reset_ch: got %0d, required 0", bus.o_ch); end
        if (bus.o_active !== 1'b0) begin n_errors++; $display("FAIL reset_active: got %b, required 0", bus.o_active); end
        model_reset();
        queue_words(1);
        i_reset = 1'b0;
        run_words(1);
        n_checks++;
        if (ren_ch != 0) begin n_errors++; $display("FAIL reset_first_grant: got ch %0d, required 0", ren_ch); end
    endtask

    task automatic test_round_robin();
        int r0;
        bus.i_ch_mask = 4'hF;
        bus.i_empty   = 4'h0;
        r0 = ren_count;
        queue_words(6);
        run_words(6);
        n_checks++;
        if (ren_count - r0 != 6) begin
            n_errors++;
            $display("FAIL rr_one_ren_per_frame: got %0d strobes, required 6", ren_count - r0);
        end
    endtask

    task automatic test_mask_skip();
        bus.i_ch_mask = 4'b1010;
        bus.i_empty   = 4'h0;
        queue_words(4);
        run_words(4);
        bus.i_empty[3] = 1'b1;
        queue_words(3);
        run_words(3);
        n_checks++;
        if (ren_ch != 1) begin n_errors++; $display("FAIL mask_single: got ch %0d, required 1", ren_ch); end
    endtask

    task automatic test_disable_mid();
        int t = 0;
        int r0;
        bus.i_ch_mask = 4'hF;
        bus.i_empty   = 4'h0;
        queue_words(1);
        bus.i_enable = 1'b1;
        while (!(bus.o_dv === 1'b1 && bus.o_ch === 2'd2) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= TMO) begin n_errors++; $display("FAIL disable_wait: no ch2 word within %0d cycles, required one", TMO); end
        repeat (2) @(negedge clk);
        bus.i_enable = 1'b0;
        wait_idle();
        r0 = ren_count;
        repeat (20) @(negedge clk);
        n_checks++;
        if (ren_count != r0) begin
            n_errors++;
            $display("FAIL disable_no_ren: got %0d strobes while disabled, required 0", ren_count - r0);
        end
        queue_words(1);
        run_words(1);
        n_checks++;
        if (ren_ch != 3) begin n_errors++; $display("FAIL disable_resume: got ch %0d, required 3", ren_ch); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        bus.i_ch_mask = 4'hF;
        bus.i_empty   = 4'h0;
        queue_words(1);
        bus.i_enable = 1'b1;
        while (bus.o_dv !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (bus.o_dv !== 1'b0) begin n_errors++; $display("FAIL midreset_dv: got %b, required 0", bus.o_dv); end
        if (bus.o_active !== 1'b0) begin n_errors++; $display("FAIL midreset_idle: o_active=%b, required 0", bus.o_active); end
        if (bus.o_r_en !== 4'b0000) begin n_errors++; $display("FAIL midreset_r_en: got %b, required 0000", bus.o_r_en); end
        @(negedge clk);
        model_reset();
        queue_words(1);
        i_reset = 1'b0;
        run_words(1);
        n_checks++;
        if (ren_ch != 0) begin n_errors++; $display("FAIL midreset_ptr: got ch %0d, required 0", ren_ch); end
    endtask

    task automatic test_timeout();
        bus.i_ch_mask = 4'hF;
        bus.i_empty   = 4'h0;
        uart_silent   = 1'b1;
        queue_words(3);
        run_words(3);
        uart_silent = 1'b0;
        n_checks++;
        if (last_gap != 5) begin n_errors++; $display("FAIL timeout_gap: got %0d cycles, required 5", last_gap); end
    endtask

`ifdef FIFO_UART_CH_TAG_EN
    task automatic test_tag();
        int r0;
        fifo_data[0] = 8'h55;
        fifo_data[2] = 8'h66;
        bus.i_ch_mask = 4'hF;
        bus.i_empty   = 4'b1010;
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        i_reset = 1'b0;
        r0 = ren_count;
        queue_words(3);
        run_words(3);
        n_checks++;
        if (ren_count - r0 != 3) begin n_errors++; $display("FAIL tag_strobes: got %0d, required 3", ren_count - r0); end
        bus.i_empty = 4'b1110;
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        i_reset = 1'b0;
        queue_words(3);
        run_words(3);
    endtask
`endif

    initial begin
        for (int c = 0; c < N_CH; c++) fifo_data[c] = 8'hA0 + 8'(c);
        bus.i_busy   = 1'b0;
        bus.i_enable = 1'b0;
        test_reset();
`ifdef FIFO_UART_CH_TAG_EN
        test_tag();
`else
        test_round_robin();
        test_mask_skip();
        test_disable_mid();
        test_reset_mid();
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
        $fatal(1);
    end

endmodule
